frac_mul_unit: RTL and testbench

//  Sequential signed fractional multiplier feeding the picoMIPS register file write port.

---
 rtl/frac_mul_unit.sv | 87 ++++++++
 tb/tb_frac_mul_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/frac_mul_unit.sv
// Sequential signed Q1.(n-1) fractional multiplier, radix-2 shift-add over n cycles.
// done is a one-cycle strobe intended as the register-file write enable.
module frac_mul_unit #(
  parameter int unsigned n   = 8,
  parameter bit          SAT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result
);

  localparam int unsigned W2 = 2 * n;
  localparam int unsigned CW = $clog2(n);
  localparam logic [n-1:0] MIN_VAL = {1'b1, {(n-1){1'b0}}};
  localparam logic [n-1:0] MAX_VAL = {1'b0, {(n-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [n-1:0]    a_r;
  logic [n-1:0]    b_r;
  logic [CW-1:0]   cnt;
  logic [W2-1:0]   acc;

  logic [W2-1:0]   pp_c;
  logic [W2-1:0]   acc_nxt_c;
  logic [n-1:0]    res_nxt_c;
  logic            last_c;
  logic            ovf_c;

  // Partial product for the current bit; the sign bit of b carries negative weight.
  always_comb begin
    pp_c      = {{n{a_r[n-1]}}, a_r} << cnt;
    acc_nxt_c = acc;
    last_c    = (cnt == CW'(n - 1));
    if (b_r[cnt]) begin
      acc_nxt_c = last_c ? (acc - pp_c) : (acc + pp_c);
    end
    ovf_c     = (a_r == MIN_VAL) && (b_r == MIN_VAL);
    res_nxt_c = (SAT && ovf_c) ? MAX_VAL : acc_nxt_c[W2-2:n-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt_c;
          cnt <= cnt + CW'(1);
          if (last_c) begin
            result <= res_nxt_c;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_mul_unit.sv
// Bench for frac_mul_unit: vector table, hand-written corner sequences and random ops
// checked against an integer-arithmetic reference model (one SAT=1 and one SAT=0 instance).
module tb_frac_mul_unit;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] a, b;
  logic         busy1, done1, busy0, done0;
  logic [N-1:0] res1, res0;

  int tests = 0;
  int fails = 0;
  logic [N-1:0] prev1, prev0;

  frac_mul_unit #(.n(N), .SAT(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(res1)
  );

  frac_mul_unit #(.n(N), .SAT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(res0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_sat;
    logic [N-1:0] exp_wrap;
  } vec_t;

  // Reference: exact integer product, floor by arithmetic shift, saturate only +1.0.
  function automatic logic [N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input bit sat);
    int p, q;
    p = int'($signed(x)) * int'($signed(y));
    q = p >>> (N - 1);
    if (sat && q == (1 << (N - 1))) q = (1 << (N - 1)) - 1;
    return q[N-1:0];
  endfunction

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: start sampled at E0, then E1..En and the DONE cycle (n+2 edges).
  task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] xb,
                        input logic [N-1:0] e1, input logic [N-1:0] e0);
    a = xa; b = xb; start = 1'b1;
    tick();
    start = 1'b0;
    a = N'($urandom); b = N'($urandom);
    chk("busy_after_E0", N'(busy1), N'(1));
    chk("done_after_E0", N'(done1), N'(0));
    for (int k = 1; k < N; k++) begin
      tick();
      chk("busy_calc", N'(busy1), N'(1));
      chk("done_calc", N'(done1), N'(0));
      chk("res_stable_calc", res1, prev1);
    end
    tick();
    chk("done_at_En", N'(done1), N'(1));
    chk("busy_at_En", N'(busy1), N'(0));
    chk("result_sat", res1, e1);
    chk("result_wrap", res0, e0);
    prev1 = e1; prev0 = e0;
    tick();
    chk("done_one_cycle", N'(done1), N'(0));
    chk("busy_after_done", N'(busy1), N'(0));
    chk("res_held", res1, prev1);
  endtask

  vec_t vecs[7];
  int   ndone;

  initial begin
    reset = 1'b1; start = 1'b1; a = 8'h40; b = 8'h40;
    prev1 = '0; prev0 = '0;

    // Reset with start asserted stays idle.
    tick(); tick();
    chk("rst_busy", N'(busy1), N'(0));
    chk("rst_done", N'(done1), N'(0));
    chk("rst_result", res1, 8'h00);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("post_rst_busy", N'(busy1), N'(0));

    vecs[0] = '{8'h40, 8'h40, 8'h20, 8'h20};
    vecs[1] = '{8'hC0, 8'h40, 8'hE0, 8'hE0};
    vecs[2] = '{8'hFF, 8'h01, 8'hFF, 8'hFF};
    vecs[3] = '{8'h7F, 8'h01, 8'h00, 8'h00};
    vecs[4] = '{8'h80, 8'h80, 8'h7F, 8'h80};
    vecs[5] = '{8'h7F, 8'h7F, 8'h7E, 8'h7E};
    vecs[6] = '{8'h80, 8'h7F, 8'h81, 8'h81};
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_sat, vecs[i].exp_wrap);
    end

    // Starts during CALC and DONE must be ignored.
    a = 8'h40; b = 8'h40; start = 1'b1;
    tick();
    ndone = 0;
    for (int c = 1; c <= N + 4; c++) begin
      start = (c == 3 || c == N + 1);
      a = 8'h11; b = 8'h7F;
      tick();
      if (done1) begin
        ndone++;
        chk("ign_result", res1, 8'h20);
      end
    end
    start = 1'b0;
    chk("ign_single_done", N'(ndone), N'(1));
    chk("ign_idle_busy", N'(busy1), N'(0));
    chk("ign_result_held", res1, 8'h20);
    prev1 = 8'h20; prev0 = 8'h20;

    // Reset in CALC cycle 5 abandons the operation.
    a = 8'h7F; b = 8'h7F; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", N'(busy1), N'(0));
    chk("mid_rst_done", N'(done1), N'(0));
    chk("mid_rst_result", res1, 8'h00);
    ndone = 0;
    for (int c = 0; c < N + 2; c++) begin
      tick();
      if (done1) ndone++;
    end
    chk("mid_rst_no_done", N'(ndone), N'(0));
    prev1 = '0; prev0 = '0;
    run_op(8'hC0, 8'hC0, 8'h20, 8'h20);

    // Random back-to-back operations.
    for (int i = 0; i < 1000; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom); rb = N'($urandom);
      if (i % 97 == 0) begin ra = 8'h80; rb = 8'h80; end
      run_op(ra, rb, ref_mul(ra, rb, 1'b1), ref_mul(ra, rb, 1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
